labfor_hex_scan: RTL



---
 rtl/labfor_hex_scan.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/labfor_hex_scan.sv
// ---------------------------------------------------------------------------
// labfor_hex_scan
//
// Time-multiplexed hexadecimal display driver for the labfor boards. A value
// of 4*DIGITS bits is shown on DIGITS seven-segment digits that share one
// segment bus. Each digit owns a slot of SCAN_DIV clock cycles. The first
// DEAD cycles of every slot are dark, which suppresses ghosting while the
// enables and segments change over.
//
// New values are captured into a pending register. They are promoted into
// the displayed shadow register only at the end of a full frame, so a single
// frame never mixes old and new digits.
//
// Parameters
//   DIGITS     number of digits (1..8)
//   SCAN_DIV   clock cycles per digit slot (2..2^20)
//   DEAD       dark cycles at the start of each slot (0..SCAN_DIV-1)
//   ACTIVE_LOW 1: seg_o, dp_o and dig_o are driven low when lit/enabled
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   data_i     value to display; nibble k drives digit k, digit 0 is the LSD
//   load_i     capture data_i (takes effect at the next frame boundary)
//   blank_lz_i blank leading zero digits (digit 0 is never blanked)
//   dp_i       decimal point per digit, used live
//   seg_o      segments {a,b,c,d,e,f,g}, a is the MSB
//   dp_o       decimal point of the active digit
//   dig_o      one-hot digit enable
//   frame_o    one-cycle pulse on the first output cycle of each new frame
// ---------------------------------------------------------------------------
module labfor_hex_scan #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEAD       = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic                  load_i,
  input  logic                  blank_lz_i,
  input  logic [DIGITS-1:0]     dp_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     dig_o,
  output logic                  frame_o
);

  // -------------------------------------------------------------------------
  // Widths and constants
  // -------------------------------------------------------------------------
  localparam int VAL_W = 4 * DIGITS;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
  // DEAD never exceeds SCAN_DIV-1, so it always fits the prescaler width.
  localparam logic [PRE_W-1:0] DEAD_V  = PRE_W'(DEAD);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  // XOR masks that apply the output polarity at the register inputs.
  localparam logic [6:0]        SEG_POL = {7{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DIG_POL = {DIGITS{ACTIVE_LOW}};
  localparam logic              DP_POL  = ACTIVE_LOW;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PRE_W-1:0] pre;      // cycle position inside the current slot
  logic [IDX_W-1:0] idx;      // digit currently being scanned
  logic [PRE_W-1:0] dead;     // dark cycles remaining in this slot
  logic [VAL_W-1:0] pend;     // most recently loaded value
  logic             pend_v;   // pend holds a value not yet shown
  logic [VAL_W-1:0] shadow;   // value being displayed this frame
  logic             wrap_q;   // frame boundary, one cycle after the last tick

  // -------------------------------------------------------------------------
  // Scan timing
  // -------------------------------------------------------------------------
  logic tick;
  logic wrap;
  logic active;

  assign tick   = (pre == PRE_MAX);
  assign wrap   = tick && (idx == IDX_MAX);
  assign active = (dead == '0);

  // -------------------------------------------------------------------------
  // Leading-zero detection
  //
  // lz[k] is set when nibbles DIGITS-1 down to k of shadow are all zero.
  // Digit 0 is excluded, so a value of zero still shows a single "0".
  // -------------------------------------------------------------------------
  logic [DIGITS-1:0] lz;
  logic              zero_run;

  always_comb begin
    // NOTE: every variable written here gets a default before any branch or
    // loop. Otherwise a path that leaves it unassigned would infer a latch.
    lz       = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (shadow[4*k +: 4] == 4'h0);
      lz[k]    = zero_run && (k != 0);
    end
  end

  // -------------------------------------------------------------------------
  // Hex to seven-segment decode, {a,b,c,d,e,f,g}, logical (1 = lit)
  // -------------------------------------------------------------------------
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      4'hF: s = 7'h47;
    endcase
    return s;
  endfunction

  // -------------------------------------------------------------------------
  // Next output values (logical polarity)
  // -------------------------------------------------------------------------
  logic [3:0]        cur_nib;
  logic              cur_blank;
  logic [6:0]        seg_next;
  logic [DIGITS-1:0] dig_next;
  logic              dp_next;

  assign cur_nib   = shadow[{idx, 2'b00} +: 4];
  assign cur_blank = blank_lz_i && lz[idx];

  // A blanked digit keeps its enable and decimal point; only the segments go
  // dark. This keeps the brightness of the remaining digits uniform.
  assign seg_next = (active && !cur_blank) ? hex7(cur_nib) : 7'h00;
  assign dig_next = active ? (DIGITS'(1) << idx) : '0;
  assign dp_next  = active ? dp_i[idx] : 1'b0;

  // -------------------------------------------------------------------------
  // Sequential logic
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments. Every register then
    // samples the pre-edge values, whatever order the statements appear in.
    if (rst) begin
      pre     <= '0;
      idx     <= '0;
      dead    <= DEAD_V;
      pend    <= '0;
      pend_v  <= 1'b0;
      shadow  <= '0;
      wrap_q  <= 1'b0;
      seg_o   <= SEG_POL;
      dp_o    <= DP_POL;
      dig_o   <= DIG_POL;
      frame_o <= 1'b0;
    end else begin
      // Prescaler and scan index.
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end

      // Dead time restarts with every slot, then counts down to zero.
      if (tick) begin
        dead <= DEAD_V;
      end else if (dead != '0) begin
        dead <= dead - 1'b1;
      end

      // Value path. A load in the wrap cycle goes straight to the display and
      // also supersedes anything still pending. Otherwise, the latest load
      // waits in pend until the frame boundary.
      if (load_i && wrap) begin
        shadow <= data_i;
        pend_v <= 1'b0;
      end else if (load_i) begin
        pend   <= data_i;
        pend_v <= 1'b1;
      end else if (wrap && pend_v) begin
        shadow <= pend;
        pend_v <= 1'b0;
      end

      // The frame pulse lines up with the first output cycle that already
      // reflects the new frame's index, dead time and shadow value.
      wrap_q  <= wrap;
      frame_o <= wrap_q;

      // Registered outputs with polarity applied.
      seg_o <= seg_next ^ SEG_POL;
      dp_o  <= dp_next ^ DP_POL;
      dig_o <= dig_next ^ DIG_POL;
    end
  end

endmodule
